rd_rx_deserializer: RTL and testbench

- Receive end of the RD two-lane serial link: deserialises SERIAL_IN0/SERIAL_IN1, framed by the gated transfer clock XFR_CLK_IN, into 12-bit word pairs.
- Checks per-word parity and writes each word pair into a capture buffer.
- Sits in the UUB fabric between the RD connector pins and the RD capture BRAM.
- Runs entirely on CLK120; the bit clock is oversampled, not used as a clock.

---
 rtl/rd_rx_pkg.sv | 21 ++
 rtl/rd_rx_edge_det.sv | 41 ++++
 rtl/rd_rx_deserializer.sv | 179 +++++++++++++++++
 tb/tb_rd_rx_deserializer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rd_rx_pkg.sv
// Shared definitions for the RD two-lane serial receiver.
// Latency: n/a (constants, types and a pure function only).
// Backpressure: n/a.
package rd_rx_pkg;

  localparam int DATA_BITS  = 12;
  localparam int FRAME_BITS = 13;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA,
    DRAIN
  } rx_state_e;

  // Odd parity: data bits XOR parity bit must be 1 for a good frame.
  function automatic logic parity_ok(input logic [FRAME_BITS-1:0] frame);
    return ^frame;
  endfunction

endpackage

// File: rtl/rd_rx_edge_det.sv
// Brings the asynchronous RD bit clock and both lanes into CLK120 and flags
// bit-clock rising edges. Latency: BIT_EVT/D0/D1 are 2 CLK120 cycles behind the pins.
// Backpressure: none; outputs are single-cycle qualifiers.
//
// Ports: CLK120, RESET (sync, active-high); XFR_CLK_IN, SERIAL_IN0/1 async pins;
//        BIT_EVT one-cycle rising-edge strobe; D0/D1 lane data aligned to BIT_EVT.
module rd_rx_edge_det (
  input  logic CLK120,
  input  logic RESET,
  input  logic XFR_CLK_IN,
  input  logic SERIAL_IN0,
  input  logic SERIAL_IN1,
  output logic BIT_EVT,
  output logic D0,
  output logic D1
);

  // Bits [1:0] are the synchroniser; bit 2 holds the previous synchronised
  // value for edge detection. The lanes use the same two-stage depth so the
  // sampled data lines up with the synchronised clock.
  logic [2:0] clk_sync;
  logic [1:0] d0_sync;
  logic [1:0] d1_sync;

  always_ff @(posedge CLK120) begin
    if (RESET) begin
      clk_sync <= '0;
      d0_sync  <= '1;   // lanes idle high
      d1_sync  <= '1;
    end else begin
      clk_sync <= {clk_sync[1:0], XFR_CLK_IN};
      d0_sync  <= {d0_sync[0], SERIAL_IN0};
      d1_sync  <= {d1_sync[0], SERIAL_IN1};
    end
  end

  assign BIT_EVT = clk_sync[1] & ~clk_sync[2];
  assign D0      = d0_sync[1];
  assign D1      = d1_sync[1];

endmodule

// File: rtl/rd_rx_deserializer.sv
// Deserialises the RD two-lane link into 12-bit word pairs with odd-parity checks.
// Latency: WE one CLK120 cycle after the synchronised parity-bit event (3 after the pin edge).
// Backpressure: none; the capture buffer must accept every WE strobe.
//
// Ports: CLK120, RESET (sync, active-high), ENABLE level; XFR_CLK_IN, SERIAL_IN0/1 from RD;
//        WRT_ADDR/WRT_DATA0/WRT_DATA1/WE buffer write port; PARITY_ERR0/1 valid with WE;
//        PERR_COUNT0/1 saturating per-transfer counts; BUSY, DONE pulse, sticky TIMEOUT_ERR.
module rd_rx_deserializer #(
  parameter int NUM_WORDS     = 2048,
  parameter int ADDR_W        = 11,
  parameter int PREAMBLE_BITS = 3,
  parameter int TIMEOUT       = 64,
  parameter int CNT_W         = 12
) (
  input  logic              CLK120,
  input  logic              RESET,
  input  logic              ENABLE,
  input  logic              XFR_CLK_IN,
  input  logic              SERIAL_IN0,
  input  logic              SERIAL_IN1,
  output logic [ADDR_W-1:0] WRT_ADDR,
  output logic [11:0]       WRT_DATA0,
  output logic [11:0]       WRT_DATA1,
  output logic              WE,
  output logic              PARITY_ERR0,
  output logic              PARITY_ERR1,
  output logic [CNT_W-1:0]  PERR_COUNT0,
  output logic [CNT_W-1:0]  PERR_COUNT1,
  output logic              BUSY,
  output logic              DONE,
  output logic              TIMEOUT_ERR
);
  import rd_rx_pkg::*;

  localparam int GAP_W  = $clog2(TIMEOUT + 1);
  localparam int PRE_W  = $clog2(PREAMBLE_BITS + 1);
  localparam int FCNT_W = $clog2(NUM_WORDS + 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(TIMEOUT);

  logic                  bit_evt, d0, d1;
  logic [GAP_W-1:0]      gap_cnt;
  logic                  quiet;
  rx_state_e             state, state_nxt;
  logic [PRE_W-1:0]      pre_cnt;
  logic [3:0]            bit_cnt;
  logic [DATA_BITS-1:0]  sh0, sh1;
  logic [FCNT_W-1:0]     frame_cnt;
  logic [FRAME_BITS-1:0] frame0, frame1;
  logic                  start, abort, frame_end, last_frame;

  rd_rx_edge_det u_edge_det (
    .CLK120     (CLK120),
    .RESET      (RESET),
    .XFR_CLK_IN (XFR_CLK_IN),
    .SERIAL_IN0 (SERIAL_IN0),
    .SERIAL_IN1 (SERIAL_IN1),
    .BIT_EVT    (bit_evt),
    .D0         (d0),
    .D1         (d1)
  );

  assign quiet = (gap_cnt == GAP_MAX);
  // The parity bit is still on the lane when the 13th event fires, so the
  // full frame is the 12 shifted data bits plus the live sample.
  assign frame0 = {sh0, d0};
  assign frame1 = {sh1, d1};
  assign BUSY   = (state != IDLE);

  always_ff @(posedge CLK120) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    start      = 1'b0;
    abort      = 1'b0;
    frame_end  = 1'b0;
    last_frame = (frame_cnt == FCNT_W'(NUM_WORDS - 1));
    if (!ENABLE) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bit_evt && quiet) begin
            start     = 1'b1;
            state_nxt = (PREAMBLE_BITS <= 1) ? DATA : PREAMBLE;
          end
        end
        PREAMBLE: begin
          if (quiet) begin
            abort     = 1'b1;
            state_nxt = IDLE;
          end else if (bit_evt && pre_cnt == PRE_W'(PREAMBLE_BITS - 1)) begin
            state_nxt = DATA;
          end
        end
        DATA: begin
          if (quiet) begin
            abort     = 1'b1;
            state_nxt = IDLE;
          end else if (bit_evt && bit_cnt == 4'(FRAME_BITS - 1)) begin
            frame_end = 1'b1;
            if (last_frame) state_nxt = DRAIN;
          end
        end
        DRAIN: begin
          if (quiet) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK120) begin
    if (RESET) begin
      gap_cnt     <= GAP_MAX;
      pre_cnt     <= '0;
      bit_cnt     <= '0;
      sh0         <= '0;
      sh1         <= '0;
      frame_cnt   <= '0;
      WRT_ADDR    <= '0;
      WRT_DATA0   <= '0;
      WRT_DATA1   <= '0;
      WE          <= 1'b0;
      PARITY_ERR0 <= 1'b0;
      PARITY_ERR1 <= 1'b0;
      PERR_COUNT0 <= '0;
      PERR_COUNT1 <= '0;
      DONE        <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      if (bit_evt)     gap_cnt <= '0;
      else if (!quiet) gap_cnt <= gap_cnt + GAP_W'(1);

      if (bit_evt) begin
        sh0 <= {sh0[DATA_BITS-2:0], d0};
        sh1 <= {sh1[DATA_BITS-2:0], d1};
      end

      if (start)                            pre_cnt <= PRE_W'(1);
      else if (state == PREAMBLE && bit_evt) pre_cnt <= pre_cnt + PRE_W'(1);

      if (state != DATA) bit_cnt <= '0;
      else if (bit_evt)  bit_cnt <= (bit_cnt == 4'(FRAME_BITS - 1)) ? 4'd0 : bit_cnt + 4'd1;

      WE   <= frame_end;
      DONE <= frame_end && last_frame;

      if (frame_end) begin
        WRT_DATA0   <= sh0;
        WRT_DATA1   <= sh1;
        PARITY_ERR0 <= ~parity_ok(frame0);
        PARITY_ERR1 <= ~parity_ok(frame1);
      end

      // WRT_ADDR holds the current address while WE is high, then advances;
      // with NUM_WORDS = 2^ADDR_W it wraps to 0 after the final write.
      if (start)   WRT_ADDR <= '0;
      else if (WE) WRT_ADDR <= WRT_ADDR + ADDR_W'(1);

      if (start)          frame_cnt <= '0;
      else if (frame_end) frame_cnt <= frame_cnt + FCNT_W'(1);

      if (start) begin
        PERR_COUNT0 <= '0;
        PERR_COUNT1 <= '0;
      end else if (frame_end) begin
        if (!parity_ok(frame0) && PERR_COUNT0 != '1) PERR_COUNT0 <= PERR_COUNT0 + CNT_W'(1);
        if (!parity_ok(frame1) && PERR_COUNT1 != '1) PERR_COUNT1 <= PERR_COUNT1 + CNT_W'(1);
      end

      if (start)      TIMEOUT_ERR <= 1'b0;
      else if (abort) TIMEOUT_ERR <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rd_rx_deserializer.sv
// Bench for rd_rx_deserializer with a 4-frame transfer, 2-bit address and 2-bit
// saturating error counters so address wrap and counter saturation are reachable.
// Bit clock runs at CLK120/6 (3 cycles low, 3 high), data changes while it is low.
module tb_rd_rx_deserializer;

  localparam int NW = 4;
  localparam int AW = 2;
  localparam int PB = 3;
  localparam int TO = 64;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          CLK120 = 1'b0;
  logic          RESET, ENABLE, XFR_CLK_IN, SERIAL_IN0, SERIAL_IN1;
  logic [AW-1:0] WRT_ADDR;
  logic [11:0]   WRT_DATA0, WRT_DATA1;
  logic          WE, PARITY_ERR0, PARITY_ERR1, BUSY, DONE, TIMEOUT_ERR;
  logic [CW-1:0] PERR_COUNT0, PERR_COUNT1;

  rd_rx_deserializer #(.NUM_WORDS(NW), .ADDR_W(AW), .PREAMBLE_BITS(PB),
                       .TIMEOUT(TO), .CNT_W(CW)) dut (
    .CLK120(CLK120), .RESET(RESET), .ENABLE(ENABLE), .XFR_CLK_IN(XFR_CLK_IN),
    .SERIAL_IN0(SERIAL_IN0), .SERIAL_IN1(SERIAL_IN1), .WRT_ADDR(WRT_ADDR),
    .WRT_DATA0(WRT_DATA0), .WRT_DATA1(WRT_DATA1), .WE(WE),
    .PARITY_ERR0(PARITY_ERR0), .PARITY_ERR1(PARITY_ERR1),
    .PERR_COUNT0(PERR_COUNT0), .PERR_COUNT1(PERR_COUNT1),
    .BUSY(BUSY), .DONE(DONE), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #5 CLK120 = ~CLK120;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- write monitor ----------------
  typedef struct {
    logic [AW-1:0] addr;
    logic [11:0]   d0, d1;
    logic          pe0, pe1;
    logic [CW-1:0] c0, c1;
    logic          done;
  } we_rec_t;

  we_rec_t we_q[$];
  int      done_cnt = 0;

  always @(negedge CLK120) begin
    if (WE === 1'b1)
      we_q.push_back('{WRT_ADDR, WRT_DATA0, WRT_DATA1, PARITY_ERR0, PARITY_ERR1,
                       PERR_COUNT0, PERR_COUNT1, DONE});
    if (DONE === 1'b1) done_cnt++;
  end

  // ---------------- bit-level transmitter ----------------
  bit tx0[$];
  bit tx1[$];

  task automatic push_bit(input bit a, input bit b);
    tx0.push_back(a);
    tx1.push_back(b);
  endtask

  task automatic add_idle(input int n);
    repeat (n) push_bit(1'b1, 1'b1);
  endtask

  // MSB first, then the odd-parity bit, optionally inverted to force an error.
  task automatic add_frame(input logic [11:0] w0, input logic [11:0] w1, input bit f0, input bit f1);
    for (int i = 11; i >= 0; i--) push_bit(w0[i], w1[i]);
    push_bit((~^w0) ^ f0, (~^w1) ^ f1);
  endtask

  // Sends the first nbits queued bits (all if nbits < 0), then empties the queue.
  // Returns 3 CLK120 cycles after the last rising edge, with the clock low.
  task automatic send(input int nbits);
    int n;
    n = (nbits < 0 || nbits > tx0.size()) ? tx0.size() : nbits;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK120);
      XFR_CLK_IN = 1'b0;
      SERIAL_IN0 = tx0[i];
      SERIAL_IN1 = tx1[i];
      repeat (3) @(negedge CLK120);
      XFR_CLK_IN = 1'b1;
      repeat (2) @(negedge CLK120);
    end
    @(negedge CLK120);
    XFR_CLK_IN = 1'b0;
    SERIAL_IN0 = 1'b1;
    SERIAL_IN1 = 1'b1;
    tx0.delete();
    tx1.delete();
  endtask

  task automatic wait_quiet();
    repeat (TO + 12) @(negedge CLK120);
  endtask

  // ---------------- reference model for random transfers ----------------
  logic [11:0] mw0[NW], mw1[NW];
  bit          mf0[NW], mf1[NW];

  task automatic check_xfer(input string tag, input int base, input int dbase);
    int      c0, c1;
    we_rec_t r;
    c0 = 0;
    c1 = 0;
    chk({tag, " we count"}, we_q.size() - base, NW);
    for (int i = 0; i < NW; i++) begin
      if (mf0[i] && c0 < CMAX) c0++;
      if (mf1[i] && c1 < CMAX) c1++;
      if (base + i < we_q.size()) begin
        r = we_q[base + i];
        chk({tag, " addr"}, r.addr, i % (1 << AW));
        chk({tag, " data0"}, r.d0, mw0[i]);
        chk({tag, " data1"}, r.d1, mw1[i]);
        chk({tag, " perr0"}, r.pe0, mf0[i]);
        chk({tag, " perr1"}, r.pe1, mf1[i]);
        chk({tag, " count0"}, r.c0, c0);
        chk({tag, " count1"}, r.c1, c1);
        chk({tag, " done"}, r.done, i == NW - 1);
      end
    end
    chk({tag, " done pulses"}, done_cnt - dbase, 1);
    chk({tag, " addr wrapped"}, WRT_ADDR, 0);
    chk({tag, " busy after quiet"}, BUSY, 0);
    chk({tag, " timeout_err"}, TIMEOUT_ERR, 0);
  endtask

  task automatic run_random(input string tag, input int trailing, input bit all_err);
    int base, dbase;
    base  = we_q.size();
    dbase = done_cnt;
    add_idle(PB);
    for (int i = 0; i < NW; i++) begin
      mw0[i] = 12'($urandom);
      mw1[i] = 12'($urandom);
      mf0[i] = all_err ? 1'b1 : ($urandom_range(0, 3) == 0);
      mf1[i] = all_err ? 1'b1 : ($urandom_range(0, 3) == 0);
      add_frame(mw0[i], mw1[i], mf0[i], mf1[i]);
    end
    add_idle(trailing);
    send(-1);
    wait_quiet();
    check_xfer(tag, base, dbase);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [11:0] w0, w1;
    bit          f0, f1;
    int          e_addr;
    bit          e_pe0, e_pe1;
    int          e_c0, e_c1;
    bit          e_done;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int base, dbase;
    we_rec_t r;

    tbl[0] = '{12'h000, 12'hFFF, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{12'hA5C, 12'hFFE, 0, 0, 1, 0, 0, 0, 0, 0};
    tbl[2] = '{12'hFFF, 12'hFFD, 0, 0, 2, 0, 0, 0, 0, 0};
    tbl[3] = '{12'h123, 12'hFFC, 0, 0, 3, 0, 0, 0, 0, 1};
    tbl[4] = '{12'h000, 12'hFFF, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[5] = '{12'hA5C, 12'hFFE, 0, 0, 1, 0, 0, 0, 0, 0};
    tbl[6] = '{12'hFFF, 12'hFFD, 0, 1, 2, 0, 1, 0, 1, 0};
    tbl[7] = '{12'h123, 12'hFFC, 0, 0, 3, 0, 0, 0, 1, 1};

    RESET = 1'b1; ENABLE = 1'b0; XFR_CLK_IN = 1'b0; SERIAL_IN0 = 1'b1; SERIAL_IN1 = 1'b1;
    repeat (3) @(negedge CLK120);
    chk("reset outputs", {WRT_ADDR, WRT_DATA0, WRT_DATA1, WE, PARITY_ERR0, PARITY_ERR1,
                          PERR_COUNT0, PERR_COUNT1, BUSY, DONE, TIMEOUT_ERR}, 0);
    RESET = 1'b0;
    ENABLE = 1'b1;

    // Clean transfer, then the same with lane 1 word 2 parity inverted.
    for (int t = 0; t < 2; t++) begin
      base  = we_q.size();
      dbase = done_cnt;
      add_idle(PB);
      for (int i = 0; i < NW; i++)
        add_frame(tbl[t*NW+i].w0, tbl[t*NW+i].w1, tbl[t*NW+i].f0, tbl[t*NW+i].f1);
      send(-1);
      chk("busy while draining", BUSY, 1);
      wait_quiet();
      chk("table we count", we_q.size() - base, NW);
      for (int i = 0; i < NW; i++) begin
        if (base + i < we_q.size()) begin
          r = we_q[base + i];
          chk("table addr", r.addr, tbl[t*NW+i].e_addr);
          chk("table data0", r.d0, tbl[t*NW+i].w0);
          chk("table data1", r.d1, tbl[t*NW+i].w1);
          chk("table perr0", r.pe0, tbl[t*NW+i].e_pe0);
          chk("table perr1", r.pe1, tbl[t*NW+i].e_pe1);
          chk("table count0", r.c0, tbl[t*NW+i].e_c0);
          chk("table count1", r.c1, tbl[t*NW+i].e_c1);
          chk("table done", r.done, tbl[t*NW+i].e_done);
        end
      end
      chk("table done pulses", done_cnt - dbase, 1);
      chk("table busy after quiet", BUSY, 0);
      chk("table timeout_err", TIMEOUT_ERR, 0);
    end

    // Clock stops 7 bits into frame 1: abort after the gap timeout.
    base  = we_q.size();
    dbase = done_cnt;
    add_idle(PB);
    add_frame(12'hA5C, 12'h3C3, 0, 0);
    add_frame(12'hFFF, 12'h000, 0, 0);
    send(PB + 13 + 7);
    repeat (TO - 3) @(negedge CLK120);
    chk("abort not early timeout_err", TIMEOUT_ERR, 0);
    chk("abort not early busy", BUSY, 1);
    repeat (6) @(negedge CLK120);
    chk("abort timeout_err", TIMEOUT_ERR, 1);
    chk("abort busy", BUSY, 0);
    chk("abort we count", we_q.size() - base, 1);
    chk("abort done", done_cnt - dbase, 0);
    if (base < we_q.size()) chk("abort data0", we_q[base].d0, 12'hA5C);
    wait_quiet();
    chk("abort sticky", TIMEOUT_ERR, 1);

    // Reset in the middle of frame 2, after a lane 0 parity error.
    add_idle(PB);
    add_frame(12'h111, 12'h222, 1, 0);
    add_frame(12'h333, 12'h444, 0, 0);
    add_frame(12'h555, 12'h666, 0, 0);
    send(PB + 26 + 6);
    chk("pre-reset addr", WRT_ADDR, 2);
    chk("pre-reset count0", PERR_COUNT0, 1);
    RESET = 1'b1;
    @(negedge CLK120);
    chk("mid-transfer reset outputs", {WRT_ADDR, WRT_DATA0, WRT_DATA1, WE, PARITY_ERR0,
        PARITY_ERR1, PERR_COUNT0, PERR_COUNT1, BUSY, DONE, TIMEOUT_ERR}, 0);
    RESET = 1'b0;
    run_random("after reset", 0, 1'b0);

    // Full transfers with trailing idle bits; the first saturates both counters.
    run_random("saturate", 12, 1'b1);
    for (int k = 0; k < 5; k++) run_random("random", $urandom_range(0, 12), 1'b0);

    // Burst arrives while disabled; enable rises mid-burst.
    base = we_q.size();
    ENABLE = 1'b0;
    add_idle(PB);
    for (int i = 0; i < NW; i++) add_frame(12'($urandom), 12'($urandom), 0, 0);
    fork
      send(-1);
      begin
        repeat (PB * 6 + 20) @(negedge CLK120);
        ENABLE = 1'b1;
      end
    join
    wait_quiet();
    chk("late enable no we", we_q.size() - base, 0);
    chk("late enable busy", BUSY, 0);

    // Enable dropped during frame 2: two writes survive, the rest is discarded.
    base  = we_q.size();
    dbase = done_cnt;
    add_idle(PB);
    for (int i = 0; i < NW; i++) add_frame(12'($urandom), 12'($urandom), 0, 0);
    fork
      send(-1);
      begin
        repeat (6 * (PB + 26) + 10) @(negedge CLK120);
        ENABLE = 1'b0;
        @(negedge CLK120);
        chk("disable busy", BUSY, 0);
      end
    join
    chk("disable we count", we_q.size() - base, 2);
    chk("disable done", done_cnt - dbase, 0);
    ENABLE = 1'b1;
    wait_quiet();
    run_random("after enable", 4, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
